clk_div_ctrl: RTL and testbench

Run-time controller for the FIFO test clocks: write clock w_clk and read clock r_clk.
- Derives both from clk_in with independently programmable half-periods.
- Sequences start/stop so each clock only ever stops in its low phase (no runt pulses into FIFO domains).
- Accepts divisor updates through a valid/ready handshake and applies them glitch-free at each channel's next falling edge.

---
 rtl/clk_div_ctrl_pkg.sv | 22 ++
 rtl/clk_div_ctrl_chan.sv | 94 +++++++++
 rtl/clk_div_ctrl.sv | 131 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg
// Shared definitions for the FIFO test-clock controller:
//   - state_t     : FSM state encoding (IDLE=00, RUN=01, STOPPING=10; 11 unused)
//   - CNT_W_DEF   : default divisor / half-period counter width
//   - EDGE_CNT_W  : width of the optional tick edge counters
//   - sat_inc     : saturating increment for the edge counters
package clk_div_ctrl_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int EDGE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STOPPING = 2'b10
  } state_t;

  function automatic logic [EDGE_CNT_W-1:0] sat_inc(input logic [EDGE_CNT_W-1:0] v);
    return (v == '1) ? v : v + EDGE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/clk_div_ctrl_chan.sv
// clk_div_chan
// One divided-clock channel: half-period counter, active and shadow divisor,
// pending-update flag, registered clock output and rising-edge tick.
// Ports:
//   clk_in, reset_n   : clock, asynchronous active-low reset
//   i_idle            : controller in IDLE (counter held at 0, output low)
//   i_run             : controller in RUN (free-run)
//   i_stopping        : controller in STOPPING (run only while output high)
//   i_cfg_load        : load i_cfg_div straight into the active divisor
//   i_cfg_shadow      : capture i_cfg_div into the shadow and mark pending
//   i_cfg_div         : offered divisor
//   o_clk             : divided clock, half-period = active divisor + 1
//   o_tick            : one-cycle pulse in the cycle o_clk becomes 1
//   o_pending         : shadow divisor waiting for the next falling edge
module clk_div_chan #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 1
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             i_idle,
  input  logic             i_run,
  input  logic             i_stopping,
  input  logic             i_cfg_load,
  input  logic             i_cfg_shadow,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;
  logic             w_cnt_en;
  logic             w_hit;

  // While stopping, a low channel freezes; a high one runs out its phase.
  assign w_cnt_en = i_run | (i_stopping & r_clk);
  assign w_hit    = (r_cnt == r_div);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_div    <= CNT_W'(DIV_RST);
      r_shadow <= '0;
      r_pend   <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick <= 1'b0;

      if (i_idle) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
      end else if (w_cnt_en) begin
        if (w_hit) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= ~r_clk;
          // Divisor swaps only on the high->low toggle so no phase is cut short.
          if (r_clk && r_pend) begin
            r_div  <= r_shadow;
            r_pend <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      if (i_cfg_load) begin
        r_div  <= i_cfg_div;
        r_pend <= 1'b0;
      end else if (i_idle && r_pend) begin
        // An update left over from STOPPING is applied once idle.
        r_div  <= r_shadow;
        r_pend <= 1'b0;
      end

      if (i_cfg_shadow) begin
        r_shadow <= i_cfg_div;
        r_pend   <= 1'b1;
      end
    end
  end

  assign o_clk     = r_clk;
  assign o_tick    = r_tick;
  assign o_pending = r_pend;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Run-time controller for the FIFO test clocks w_clk / r_clk, both derived
// from clk_in. Start/stop sequencing guarantees each clock stops low; divisor
// pairs arrive over a valid/ready handshake and take effect glitch-free.
// Optional macro CLK_DIV_CTRL_STATUS_EN adds saturating tick counters
// w_edge_cnt / r_edge_cnt (cleared by reset or IDLE->RUN).
// Ports:
//   clk_in, reset_n        : clock, asynchronous active-low reset
//   start, stop            : level-sampled run requests (stop wins)
//   cfg_valid / cfg_ready  : divisor-pair handshake
//   cfg_w_div, cfg_r_div   : offered divisors
//   w_clk, r_clk           : divided clocks (registered)
//   w_tick, r_tick         : pulses coincident with the rising transitions
//   busy                   : state != IDLE
//   state                  : FSM state encoding
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int W_DIV_RST = 1,
  parameter int R_DIV_RST = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_w_div,
  input  logic [CNT_W-1:0] cfg_r_div,
  output logic             w_clk,
  output logic             r_clk,
  output logic             w_tick,
  output logic             r_tick,
  output logic             busy,
  output logic [1:0]       state
`ifdef CLK_DIV_CTRL_STATUS_EN
  ,
  output logic [EDGE_CNT_W-1:0] w_edge_cnt,
  output logic [EDGE_CNT_W-1:0] r_edge_cnt
`endif
);

  state_t r_state;
  logic   w_idle;
  logic   w_run;
  logic   w_stopping;
  logic   w_fire;
  logic   w_w_pend;
  logic   w_r_pend;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_run      = (r_state == ST_RUN);
  assign w_stopping = (r_state == ST_STOPPING);

  // In RUN a new pair is refused until both channels consumed the last one.
  assign cfg_ready = w_idle | (w_run & ~w_w_pend & ~w_r_pend);
  assign w_fire    = cfg_valid & cfg_ready;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (start && !stop)  r_state <= ST_RUN;
        ST_RUN:      if (stop)            r_state <= ST_STOPPING;
        ST_STOPPING: if (!w_clk && !r_clk) r_state <= ST_IDLE;
        default:                          r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = ~w_idle;
  assign state = r_state;

  clk_div_chan #(
    .CNT_W   (CNT_W),
    .DIV_RST (W_DIV_RST)
  ) u_w_chan (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .i_idle       (w_idle),
    .i_run        (w_run),
    .i_stopping   (w_stopping),
    .i_cfg_load   (w_fire & w_idle),
    .i_cfg_shadow (w_fire & w_run),
    .i_cfg_div    (cfg_w_div),
    .o_clk        (w_clk),
    .o_tick       (w_tick),
    .o_pending    (w_w_pend)
  );

  clk_div_chan #(
    .CNT_W   (CNT_W),
    .DIV_RST (R_DIV_RST)
  ) u_r_chan (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .i_idle       (w_idle),
    .i_run        (w_run),
    .i_stopping   (w_stopping),
    .i_cfg_load   (w_fire & w_idle),
    .i_cfg_shadow (w_fire & w_run),
    .i_cfg_div    (cfg_r_div),
    .o_clk        (r_clk),
    .o_tick       (r_tick),
    .o_pending    (w_r_pend)
  );

`ifdef CLK_DIV_CTRL_STATUS_EN
  logic [EDGE_CNT_W-1:0] r_w_edge_cnt;
  logic [EDGE_CNT_W-1:0] r_r_edge_cnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_w_edge_cnt <= '0;
      r_r_edge_cnt <= '0;
    end else if (w_idle && start && !stop) begin
      r_w_edge_cnt <= '0;
      r_r_edge_cnt <= '0;
    end else begin
      if (w_tick) r_w_edge_cnt <= sat_inc(r_w_edge_cnt);
      if (r_tick) r_r_edge_cnt <= sat_inc(r_r_edge_cnt);
    end
  end

  assign w_edge_cnt = r_w_edge_cnt;
  assign r_edge_cnt = r_r_edge_cnt;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       start, stop, cfg_valid, cfg_ready;
  logic [7:0] cfg_w_div, cfg_r_div;
  logic       w_clk, r_clk, w_tick, r_tick, busy;
  logic [1:0] state;
`ifdef CLK_DIV_CTRL_STATUS_EN
  logic [15:0] w_edge_cnt, r_edge_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per channel, cycles remaining in the current phase.
  int m_st;          // 0 idle, 1 run, 2 stopping
  bit m_out [2];
  int m_rem [2];
  int m_div [2];
  int m_sh  [2];
  bit m_pend[2];
  bit m_tick[2];
  int m_ecnt[2];

  clk_div_ctrl #(
    .CNT_W     (8),
    .W_DIV_RST (1),
    .R_DIV_RST (2)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_w_div (cfg_w_div),
    .cfg_r_div (cfg_r_div),
    .w_clk     (w_clk),
    .r_clk     (r_clk),
    .w_tick    (w_tick),
    .r_tick    (r_tick),
    .busy      (busy),
    .state     (state)
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    .w_edge_cnt(w_edge_cnt),
    .r_edge_cnt(r_edge_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return (m_st == 0) || (m_st == 1 && !m_pend[0] && !m_pend[1]);
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_div[0] = 1;
    m_div[1] = 2;
    for (int c = 0; c < 2; c++) begin
      m_out[c]  = 0;
      m_pend[c] = 0;
      m_tick[c] = 0;
      m_ecnt[c] = 0;
      m_sh[c]   = 0;
      m_rem[c]  = m_div[c] + 1;
    end
  endtask

  task automatic compare_all();
    chk("w_clk", w_clk, m_out[0]);
    chk("r_clk", r_clk, m_out[1]);
    chk("w_tick", w_tick, m_tick[0]);
    chk("r_tick", r_tick, m_tick[1]);
    chk("state", state, m_st);
    chk("busy", busy, m_st != 0);
    chk("cfg_ready", cfg_ready, model_ready());
`ifdef CLK_DIV_CTRL_STATUS_EN
    chk("w_edge_cnt", w_edge_cnt, m_ecnt[0]);
    chk("r_edge_cnt", r_edge_cnt, m_ecnt[1]);
`endif
  endtask

  // Advance model one clk_in cycle from the currently driven inputs, then
  // let the DUT take the same edge and compare.
  task automatic step();
    bit rdy;
    bit fire;
    bit both_low;
    int cv[2];
    rdy      = model_ready();
    fire     = cfg_valid && rdy;
    both_low = !m_out[0] && !m_out[1];
    cv[0]    = cfg_w_div;
    cv[1]    = cfg_r_div;
    for (int c = 0; c < 2; c++)
      if (m_tick[c] && m_ecnt[c] < 65535) m_ecnt[c]++;
    if (m_st == 0 && start && !stop) begin
      m_ecnt[0] = 0;
      m_ecnt[1] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      m_tick[c] = 0;
      if (m_st == 0) begin
        if (fire) begin
          m_div[c] = cv[c]; m_pend[c] = 0;
        end else if (m_pend[c]) begin
          m_div[c] = m_sh[c]; m_pend[c] = 0;
        end
        m_out[c] = 0;
        m_rem[c] = m_div[c] + 1;
      end else if (m_st == 1 || (m_st == 2 && m_out[c])) begin
        if (m_rem[c] == 1) begin
          if (m_out[c] && m_pend[c]) begin
            m_div[c] = m_sh[c]; m_pend[c] = 0;
          end
          m_out[c]  = !m_out[c];
          m_tick[c] = m_out[c];
          m_rem[c]  = m_div[c] + 1;
        end else begin
          m_rem[c]--;
        end
        if (m_st == 1 && fire) begin
          m_sh[c] = cv[c]; m_pend[c] = 1;
        end
      end
    end
    case (m_st)
      0: if (start && !stop) m_st = 1;
      1: if (stop) m_st = 2;
      2: if (both_low) m_st = 0;
      default: m_st = 0;
    endcase
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  function automatic logic tick_of(input int ch);
    return (ch == 0) ? w_tick : r_tick;
  endfunction

  // Cycles between two consecutive ticks of a channel.
  task automatic meas(input int ch, input int exp, input string tag);
    int n;
    int cnt;
    n = 0;
    while (!tick_of(ch) && n < 200) begin step(); n++; end
    step();
    cnt = 1;
    while (!tick_of(ch) && cnt < 200) begin step(); cnt++; end
    chk(tag, cnt, exp);
  endtask

  task automatic go_idle();
    int n;
    stop = 1; step(); stop = 0;
    n = 0;
    while (state != 2'b00 && n < 200) begin step(); n++; end
    chk("go_idle", state, 0);
  endtask

  initial begin
    int n;
    reset_n = 0; start = 0; stop = 0; cfg_valid = 0;
    cfg_w_div = 0; cfg_r_div = 0;
    model_reset();
    #12;
    // 1: reset defaults, then start with reset divisors
    compare_all();
    reset_n = 1;
    start = 1; step(); start = 0;
    step();
    chk("t1_wtick_early", w_tick, 0);
    step();
    chk("t1_first_wtick", w_tick, 1);
    chk("t1_busy", busy, 1);
    meas(0, 4, "t1_w_period");
    meas(1, 6, "t1_r_period");
    go_idle();

    // 2: config accepted in IDLE
    cfg_w_div = 0; cfg_r_div = 4; cfg_valid = 1; step(); cfg_valid = 0;
    start = 1; step(); start = 0;
    meas(0, 2, "t2_w_period");
    meas(1, 10, "t2_r_period");

    // 3: config accepted in RUN, applied at falling edges
    cfg_w_div = 3; cfg_r_div = 0; cfg_valid = 1; step(); cfg_valid = 0;
    chk("t3_ready_drop", cfg_ready, 0);
    n = 0;
    while (!cfg_ready && n < 100) begin step(); n++; end
    chk("t3_ready_back", cfg_ready, 1);
    meas(0, 8, "t3_w_period");
    meas(1, 2, "t3_r_period");

    // 4: stop while w high and r low; start during STOPPING is ignored
    n = 0;
    while (!(w_clk && !r_clk) && n < 100) begin step(); n++; end
    chk("t4_setup", {w_clk, r_clk}, 2'b10);
    stop = 1; start = 1; step(); stop = 0;
    chk("t4_stopping", state, 2);
    n = 0;
    while (state != 2'b00 && n < 100) begin step(); n++; end
    start = 0;
    chk("t4_idle", state, 0);
    chk("t4_outs_low", {w_clk, r_clk}, 2'b00);

    // 5: start and stop together in IDLE
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("t5_state", state, 0);
    chk("t5_outs", {w_clk, r_clk}, 2'b00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 31) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_w_div = 8'($urandom_range(0, 5));
      cfg_r_div = 8'($urandom_range(0, 5));
      step();
    end
    start = 0; stop = 0; cfg_valid = 0;
    go_idle();

    // 6: asynchronous reset mid-RUN with a pending config
    start = 1; step(); start = 0;
    repeat (3) step();
    cfg_w_div = 3; cfg_r_div = 3; cfg_valid = 1; step(); cfg_valid = 0;
    chk("t6_pending", cfg_ready, 0);
    #2 reset_n = 0;
    #1;
    model_reset();
    compare_all();
    #2 reset_n = 1;
    start = 1; step(); start = 0;
    meas(0, 4, "t6_w_period");
    meas(1, 6, "t6_r_period");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
